wb_slave_bridge: RTL

WB_SLAVE_BRIDGE -- requirements
Module: wb_slave_bridge

---
 rtl/wb_slave_bridge_pkg.sv | 19 +
 rtl/wb_tmo_cnt.sv | 39 +++
 rtl/wb_slave_bridge.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/wb_slave_bridge_pkg.sv
// Shared definitions for the Wishbone slave bridge: FSM encoding, timeout defaults and
// the timeout counter sizing helper.
package wb_slave_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StRdWait = 2'd2,
        StAck    = 2'd3
    } bridge_state_e;

    localparam logic [31:0] TmoDataDefault = 32'hDEAD_BEEF;

    // A zero limit disables the timeout but still needs a one-bit counter to stay legal.
    function automatic int unsigned cnt_width(int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wb_tmo_cnt.sv
// Saturating read-wait timer; expired marks the enabled cycle in which the count reaches
// the limit.
module wb_tmo_cnt
    import wb_slave_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     CntW  = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && !clear && (cnt_d == Limit);

endmodule

// File: rtl/wb_slave_bridge.sv
// Wishbone classic slave that forwards one access at a time as a valid/ready command and
// returns read data from a separate read-return channel, with a read-wait timeout.
module wb_slave_bridge
    import wb_slave_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] BASE_MASK = 32'hF000_0000,
    parameter int unsigned ADR_W     = 28,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] TMO_DATA  = TmoDataDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             cmd_val,
    input  logic             cmd_rdy,
    output logic [ADR_W-1:0] cmd_adr,
    output logic             cmd_we,
    output logic [3:0]       cmd_sel,
    output logic [31:0]      cmd_dat,
    input  logic             rd_ack,
    input  logic [31:0]      rd_dat,
    output logic             busy,
    output logic             tmo
);

    bridge_state_e    state_q, state_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic             we_q, we_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             tmo_q, tmo_d;
    logic             abort_q, abort_d;
    logic             tmr_clear, tmr_enable, tmr_expired;
    logic             addr_hit;

    assign addr_hit = ((wbs_adr_i & BASE_MASK) == BASE_ADDR);

    wb_tmo_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        we_d       = we_q;
        sel_d      = sel_q;
        dat_d      = dat_q;
        rdata_d    = rdata_q;
        tmo_d      = 1'b0;
        abort_d    = abort_q;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;

        // A master that lets go of the cycle forfeits its ack; the command side still drains.
        if ((state_q != StIdle) && !wbs_cyc_i) begin
            abort_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (wbs_cyc_i && wbs_stb_i && addr_hit) begin
                    adr_d   = wbs_adr_i[ADR_W-1:0];
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    dat_d   = wbs_dat_i;
                    abort_d = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (cmd_rdy) begin
                    if (we_q) begin
                        state_d = StAck;
                    end else begin
                        tmr_clear = 1'b1;
                        state_d   = StRdWait;
                    end
                end
            end
            StRdWait: begin
                tmr_enable = !rd_ack;
                if (rd_ack) begin
                    rdata_d = rd_dat;
                    state_d = StAck;
                end else if (tmr_expired) begin
                    rdata_d = TMO_DATA;
                    tmo_d   = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            abort_q <= abort_d;
        end
    end

    assign wbs_ack_o = (state_q == StAck) && wbs_cyc_i && !abort_q;
    assign wbs_dat_o = rdata_q;
    assign cmd_val   = (state_q == StIssue);
    assign cmd_adr   = adr_q;
    assign cmd_we    = we_q;
    assign cmd_sel   = sel_q;
    assign cmd_dat   = dat_q;
    assign busy      = (state_q != StIdle);
    assign tmo       = tmo_q;

endmodule
